// File: rtl/video_pkg.sv
// video_pkg: mode encodings, Bayer dither table and width helper shared by the depth converter
package video_pkg;

    typedef enum logic [1:0] {
        MODE_TRUNC  = 2'd0,
        MODE_ROUND  = 2'd1,
        MODE_DITHER = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // 2x2 ordered-dither thresholds indexed by {yp, xp}
    localparam logic [1:0] BAYER [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

    function automatic int round_up8(int w);
        return (w + 7) / 8 * 8;
    endfunction

    function automatic logic [1:0] bayer(logic xp, logic yp);
        return BAYER[{yp, xp}];
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry AXI-Stream register slice (output register + skid register)
//   clk, rstn             clock, asynchronous active-low reset
//   s_data/s_valid/s_ready upstream beat; s_ready is registered and means "skid empty"
//   m_data/m_valid/m_ready downstream beat, held stable while stalled
module axis_skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    logic [DATA_W-1:0] skid_data;
    logic              skid_valid;
    logic              accept;
    logic              load;

    assign accept = s_valid & s_ready;
    // output register can take a new beat when empty or draining this cycle
    assign load   = m_ready | ~m_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            s_ready    <= 1'b0;
        end else begin
            if (load) begin
                m_valid <= skid_valid | accept;
                if (skid_valid)
                    m_data <= skid_data;
                else if (accept)
                    m_data <= s_data;
            end
            skid_valid <= load ? 1'b0 : (skid_valid | accept);
            if (!load && accept)
                skid_data <= s_data;
            s_ready    <= load | ~(skid_valid | accept);
        end
    end

endmodule

// File: rtl/video_depth_convert.sv
// video_depth_convert: reduces per-component bit depth by truncation, rounding or 2x2 ordered dither
//   clk, rstn                     clock, asynchronous active-low reset
//   cfg_mode                      0 truncate, 1 round-half-up, 2 dither, 3 truncate; latched on tuser
//   s_axis_video_*                input pixels, CHANNELS x IN_BPC components
//   m_axis_video_*                output pixels, CHANNELS x OUT_BPC components, pad bits zero
module video_depth_convert
    import video_pkg::*;
#(
    parameter  int IN_BPC   = 10,
    parameter  int OUT_BPC  = 8,
    parameter  int CHANNELS = 3,
    localparam int S_W      = round_up8(CHANNELS * IN_BPC),
    localparam int M_W      = round_up8(CHANNELS * OUT_BPC)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [1:0]     cfg_mode,
    input  logic [S_W-1:0] s_axis_video_tdata,
    input  logic           s_axis_video_tvalid,
    input  logic           s_axis_video_tuser,
    input  logic           s_axis_video_tlast,
    output logic           s_axis_video_tready,
    output logic [M_W-1:0] m_axis_video_tdata,
    output logic           m_axis_video_tvalid,
    output logic           m_axis_video_tuser,
    output logic           m_axis_video_tlast,
    input  logic           m_axis_video_tready
);

    localparam int D     = IN_BPC - OUT_BPC;
    localparam int SUM_W = IN_BPC + 1;

    logic             xp;
    logic             yp;
    mode_e            act_mode;
    mode_e            cur_mode;
    logic             accept;
    logic             xp_e;
    logic             yp_e;
    logic [D+1:0]     dith;
    logic [SUM_W-1:0] off;
    logic [M_W-1:0]   conv;
    logic [M_W+1:0]   out_beat;

    assign accept   = s_axis_video_tvalid & s_axis_video_tready;
    // a start-of-frame beat sits at the origin and picks up the new mode itself
    assign xp_e     = s_axis_video_tuser ? 1'b0 : xp;
    assign yp_e     = s_axis_video_tuser ? 1'b0 : yp;
    assign cur_mode = s_axis_video_tuser ? mode_e'(cfg_mode) : act_mode;
    // floor(B * 2^D / 4): place B above D zero bits, then drop two bits
    assign dith     = {bayer(xp_e, yp_e), {D{1'b0}}};
    assign off      = cur_mode == MODE_ROUND  ? SUM_W'(1) << (D - 1) :
                      cur_mode == MODE_DITHER ? SUM_W'(dith >> 2) : '0;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] shifted;
        assign sum     = {1'b0, s_axis_video_tdata[c*IN_BPC +: IN_BPC]} + off;
        assign shifted = sum >> D;
        assign conv[c*OUT_BPC +: OUT_BPC] = |shifted[SUM_W-1:OUT_BPC] ? {OUT_BPC{1'b1}} : shifted[OUT_BPC-1:0];
    end

    if (M_W > CHANNELS * OUT_BPC) begin : g_out_pad
        assign conv[M_W-1:CHANNELS*OUT_BPC] = '0;
    end

    if (S_W > CHANNELS * IN_BPC) begin : g_in_pad
        logic unused_pad;
        assign unused_pad = ^s_axis_video_tdata[S_W-1:CHANNELS*IN_BPC];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xp       <= 1'b0;
            yp       <= 1'b0;
            act_mode <= MODE_TRUNC;
        end else if (accept) begin
            xp       <= s_axis_video_tlast ? 1'b0 : ~xp_e;
            yp       <= s_axis_video_tlast ? ~yp_e : yp_e;
            act_mode <= cur_mode;
        end
    end

    axis_skid_buffer #(
        .DATA_W (M_W + 2)
    ) u_skid (
        .clk     (clk),
        .rstn    (rstn),
        .s_data  ({s_axis_video_tuser, s_axis_video_tlast, conv}),
        .s_valid (s_axis_video_tvalid),
        .s_ready (s_axis_video_tready),
        .m_data  (out_beat),
        .m_valid (m_axis_video_tvalid),
        .m_ready (m_axis_video_tready)
    );

    assign {m_axis_video_tuser, m_axis_video_tlast, m_axis_video_tdata} = out_beat;

endmodule

// File: tb/tb_video_depth_convert.sv
// tb_video_depth_convert: scoreboard bench for the video depth converter
module tb_video_depth_convert;

    localparam int IN_BPC  = 10;
    localparam int OUT_BPC = 8;
    localparam int CH      = 3;
    localparam int D       = IN_BPC - OUT_BPC;
    localparam int S_W     = 32;
    localparam int M_W     = 24;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [1:0]     cfg_mode = 2'd0;
    logic [S_W-1:0] s_tdata = '0;
    logic           s_tvalid = 1'b0;
    logic           s_tuser = 1'b0;
    logic           s_tlast = 1'b0;
    logic           s_tready;
    logic [M_W-1:0] m_tdata;
    logic           m_tvalid;
    logic           m_tuser;
    logic           m_tlast;
    logic           m_tready = 1'b1;

    always #5 clk = ~clk;

    video_depth_convert #(
        .IN_BPC   (IN_BPC),
        .OUT_BPC  (OUT_BPC),
        .CHANNELS (CH)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .cfg_mode            (cfg_mode),
        .s_axis_video_tdata  (s_tdata),
        .s_axis_video_tvalid (s_tvalid),
        .s_axis_video_tuser  (s_tuser),
        .s_axis_video_tlast  (s_tlast),
        .s_axis_video_tready (s_tready),
        .m_axis_video_tdata  (m_tdata),
        .m_axis_video_tvalid (m_tvalid),
        .m_axis_video_tuser  (m_tuser),
        .m_axis_video_tlast  (m_tlast),
        .m_axis_video_tready (m_tready)
    );

    typedef struct {
        logic [M_W+1:0] v;
        int             acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rcv = 0;
    int   stall_lo = -1;
    int   stall_hi = -1;
    bit   lat_chk = 0;
    bit   stream_chk = 0;
    bit   rand_bp = 0;
    bit   acc_flag = 0;
    int   mxp = 0;
    int   myp = 0;
    int   mmode = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference: independent integer arithmetic plus frame-position tracking
    function automatic logic [M_W+1:0] model(logic [S_W-1:0] d, logic u, logic l);
        int xe, ye, me, b, off, o;
        logic [M_W-1:0] r;
        r  = '0;
        xe = u ? 0 : mxp;
        ye = u ? 0 : myp;
        me = u ? int'(cfg_mode) : mmode;
        b  = (ye == 0) ? ((xe == 0) ? 0 : 2) : ((xe == 0) ? 3 : 1);
        off = (me == 1) ? (1 << (D - 1)) : (me == 2) ? (b * (1 << D)) / 4 : 0;
        for (int c = 0; c < CH; c++) begin
            o = (int'(d[c*IN_BPC +: IN_BPC]) + off) >> D;
            if (o > (1 << OUT_BPC) - 1) o = (1 << OUT_BPC) - 1;
            r[c*OUT_BPC +: OUT_BPC] = OUT_BPC'(o);
        end
        mmode = me;
        mxp   = l ? 0 : 1 - xe;
        myp   = l ? 1 - ye : ye;
        return {u, l, r};
    endfunction

    function automatic logic [S_W-1:0] mk(int v);
        logic [S_W-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r[c*IN_BPC +: IN_BPC] = IN_BPC'(v);
        return r;
    endfunction

    function automatic logic [S_W-1:0] rnd();
        logic [S_W-1:0] r;
        r = S_W'($urandom());
        for (int c = 0; c < CH; c++)
            r[c*IN_BPC +: IN_BPC] = IN_BPC'(($urandom_range(0, 3) == 0) ? $urandom_range(1020, 1023) : $urandom_range(0, 1023));
        return r;
    endfunction

    // inputs are set at a falling edge; handshakes seen here happen at the next rising edge
    task automatic tick();
        m_tready = !(cyc >= stall_lo && cyc <= stall_hi) && (!rand_bp || $urandom_range(0, 1) == 1);
        acc_flag = s_tvalid && s_tready;
        if (stream_chk && cyc == stall_lo + 1) check("stall_ready_low", s_tready, 0);
        if (stream_chk && cyc == stall_hi + 2) check("stall_ready_back", s_tready, 1);
        if (m_tvalid) begin
            if (q.size() == 0) check("spurious_valid", m_tvalid, 0);
            else begin
                check("beat", {m_tuser, m_tlast, m_tdata}, q[0].v);
                if (m_tready) begin
                    if (lat_chk) check("latency", cyc - q[0].acc, 1);
                    void'(q.pop_front());
                    rcv++;
                end
            end
        end
        if (acc_flag) q.push_back('{model(s_tdata, s_tuser, s_tlast), cyc});
        cyc++;
        @(negedge clk);
    endtask

    task automatic send_beat(logic [S_W-1:0] d, logic u, logic l);
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (acc_flag) break;
        end
        if (!acc_flag) check("accept_timeout", acc_flag, 1);
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(int w, int h, int mode, int fixed, bit gaps);
        cfg_mode = 2'(mode);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                send_beat(fixed >= 0 ? mk(fixed) : rnd(), x == 0 && y == 0, x == w - 1);
                if (gaps && $urandom_range(0, 2) == 0) tick();
            end
    endtask

    task automatic drain();
        s_tvalid = 1'b0;
        for (int i = 0; i < 300 && q.size() != 0; i++) tick();
        repeat (2) tick();
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        int rcv0;
        repeat (3) @(negedge clk);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tuser", m_tuser, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_s_tready", s_tready, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_rst", s_tready, 1);

        lat_chk = 1;
        cfg_mode = 2'd0;
        send_beat(mk('h203), 1, 1);
        drain();
        cfg_mode = 2'd1;
        send_beat(mk('h3FF), 1, 0);
        send_beat(mk('h201), 0, 1);
        drain();
        send_frame(2, 2, 2, 'h201, 0);
        drain();
        cfg_mode = 2'd0;
        send_beat(mk('h202), 1, 0);
        cfg_mode = 2'd1;
        send_beat(mk('h202), 0, 0);
        send_beat(mk('h202), 0, 1);
        send_beat(mk('h202), 1, 1);
        drain();

        lat_chk = 0;
        stream_chk = 1;
        rcv0 = rcv;
        stall_lo = cyc + 10;
        stall_hi = cyc + 14;
        send_frame(8, 8, 2, -1, 0);
        drain();
        check("stream_count", rcv - rcv0, 64);
        stream_chk = 0;
        stall_lo = -1;
        stall_hi = -1;

        rand_bp = 1;
        send_frame(6, 4, 1, -1, 1);
        send_frame(5, 3, 3, -1, 1);
        send_frame(4, 4, 2, -1, 1);
        send_frame(3, 3, 0, -1, 1);
        rand_bp = 0;
        drain();

        stall_lo = cyc;
        stall_hi = cyc + 100000;
        send_frame(2, 1, 1, -1, 0);
        check("full_s_tready", s_tready, 0);
        check("full_m_tvalid", m_tvalid, 1);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_m_tvalid", m_tvalid, 0);
        check("async_rst_s_tready", s_tready, 0);
        q.delete();
        mxp = 0;
        myp = 0;
        mmode = 0;
        @(negedge clk);
        rstn = 1'b1;
        stall_lo = -1;
        stall_hi = -1;
        @(negedge clk);
        send_frame(3, 2, 2, -1, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
